// File: rtl/jk_cmd_pkg.sv
// Shared types for the JK command issuer: command opcodes, issue FSM states
// and the default vector width.
package jk_cmd_pkg;

   localparam int JK_WIDTH_DEFAULT = 32;

   typedef enum logic [1:0] {
      OP_SET   = 2'd0,
      OP_CLR   = 2'd1,
      OP_TOG   = 2'd2,
      OP_PULSE = 2'd3
   } cmd_op_t;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_PULSE_CLR = 2'd2
   } issue_state_t;

endpackage

// File: rtl/jk_cmd_fifo.sv
// Command FIFO for jk_cmd_issuer: DEPTH entries (power of two), push and pop
// on the same edge both take effect, synchronous active-high reset.
module jk_cmd_fifo #(
   parameter int WIDTH = 34,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
   localparam logic [PW:0]   CNT_FULL = (PW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PW-1:0]    wr_ptr_r;
   logic [PW-1:0]    rd_ptr_r;
   logic [PW:0]      count_r;
   logic             do_push_s;
   logic             do_pop_s;

   assign full      = (count_r == CNT_FULL);
   assign empty     = (count_r == '0);
   assign do_push_s = push && !full;
   assign do_pop_s  = pop && !empty;
   assign pop_data  = mem_r[rd_ptr_r];

   // Storage array; contents need no reset since occupancy gates every read.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   // Pointers wrap naturally at DEPTH; occupancy tracks push minus pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/jk_cmd_issuer.sv
// Queues SET/CLR/TOG/PULSE commands and issues them as one-cycle J/K vectors
// to a downstream JK register bank. Optional issue counter: JK_CMD_ISSUER_COUNT_EN.
module jk_cmd_issuer
   import jk_cmd_pkg::*;
#(
   parameter int WIDTH = JK_WIDTH_DEFAULT,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_mask,
   output logic [WIDTH-1:0] J,
   output logic [WIDTH-1:0] K,
   output logic             busy
`ifdef JK_CMD_ISSUER_COUNT_EN
   ,
   output logic [15:0]      issue_count
`endif
);

   localparam int FW = WIDTH + 2;

   logic             fifo_full_s;
   logic             fifo_empty_s;
   logic             push_s;
   logic             pop_s;
   logic [FW-1:0]    push_data_s;
   logic [FW-1:0]    pop_data_s;
   cmd_op_t          head_op_s;
   logic [WIDTH-1:0] head_mask_s;
   issue_state_t     state_r;
   logic [WIDTH-1:0] pulse_mask_r;
   logic [WIDTH-1:0] j_r;
   logic [WIDTH-1:0] k_r;

   assign push_s      = cmd_valid && !fifo_full_s;
   assign push_data_s = {cmd_op, cmd_mask};
   // The PULSE_CLR cycle owns the J/K outputs, so the queue head waits.
   assign pop_s       = (state_r != ST_PULSE_CLR) && !fifo_empty_s;
   assign head_op_s   = cmd_op_t'(pop_data_s[FW-1:WIDTH]);
   assign head_mask_s = pop_data_s[WIDTH-1:0];

   assign cmd_ready = !fifo_full_s;
   assign busy      = !fifo_empty_s || (state_r != ST_IDLE);
   assign J         = j_r;
   assign K         = k_r;

   jk_cmd_fifo #(
      .WIDTH (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_s),
      .push_data (push_data_s),
      .pop       (pop_s),
      .pop_data  (pop_data_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s)
   );

   // Issue FSM: pops the head and registers its J/K pattern; J/K idle at zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         j_r          <= '0;
         k_r          <= '0;
         pulse_mask_r <= '0;
      end else begin
         case (state_r)
            ST_IDLE, ST_ISSUE: begin
               if (pop_s) begin
                  case (head_op_s)
                     OP_SET: begin
                        j_r     <= head_mask_s;
                        k_r     <= '0;
                        state_r <= ST_ISSUE;
                     end
                     OP_CLR: begin
                        j_r     <= '0;
                        k_r     <= head_mask_s;
                        state_r <= ST_ISSUE;
                     end
                     OP_TOG: begin
                        j_r     <= head_mask_s;
                        k_r     <= head_mask_s;
                        state_r <= ST_ISSUE;
                     end
                     OP_PULSE: begin
                        j_r          <= head_mask_s;
                        k_r          <= '0;
                        pulse_mask_r <= head_mask_s;
                        state_r      <= ST_PULSE_CLR;
                     end
                     default: begin
                        j_r     <= '0;
                        k_r     <= '0;
                        state_r <= ST_ISSUE;
                     end
                  endcase
               end else begin
                  j_r     <= '0;
                  k_r     <= '0;
                  state_r <= ST_IDLE;
               end
            end
            ST_PULSE_CLR: begin
               j_r     <= '0;
               k_r     <= pulse_mask_r;
               state_r <= fifo_empty_s ? ST_IDLE : ST_ISSUE;
            end
            default: begin
               j_r     <= '0;
               k_r     <= '0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef JK_CMD_ISSUER_COUNT_EN
   logic [15:0] issue_count_r;

   // One count per popped entry, so a PULSE counts once; wraps at 16 bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         issue_count_r <= 16'd0;
      end else if (pop_s) begin
         issue_count_r <= issue_count_r + 16'd1;
      end else begin
         issue_count_r <= issue_count_r;
      end
   end

   assign issue_count = issue_count_r;
`endif

endmodule

// File: tb/tb_jk_cmd_issuer.sv
// Self-checking bench for jk_cmd_issuer: directed scenarios plus random traffic
// against a queue-based reference model and a downstream JK register model.
module tb_jk_cmd_issuer;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] m;
   } cmd_t;

   logic        clk;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [31:0] cmd_mask;
   logic [31:0] J;
   logic [31:0] K;
   logic        busy;
`ifdef JK_CMD_ISSUER_COUNT_EN
   logic [15:0] issue_count;
`endif

   int total = 0;
   int bad   = 0;

   // reference model state
   cmd_t        q[$];
   logic        pend  = 1'b0;
   logic [31:0] pmask = '0;
   logic [31:0] ej    = '0;
   logic [31:0] ek    = '0;
   logic [31:0] rq    = '0;
   logic [31:0] dq    = '0;
   logic [15:0] ecnt  = '0;
   logic        last_acc;
   logic        saw_full;

   jk_cmd_issuer #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_mask  (cmd_mask),
      .J         (J),
      .K         (K),
      .busy      (busy)
`ifdef JK_CMD_ISSUER_COUNT_EN
      ,
      .issue_count (issue_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // One clock: predict from the spec rules, apply inputs, check after the edge.
   task automatic cyc(input logic v, input logic [1:0] op, input logic [31:0] m, input logic rst);
      cmd_t c;
      cmd_t n;
      logic popped;
      popped   = 1'b0;
      last_acc = 1'b0;
      if (rst) begin
         if (pend) rq = rq | pmask;
         q.delete();
         pend = 1'b0;
         ej   = '0;
         ek   = '0;
         ecnt = '0;
      end else begin
         last_acc = v && (q.size() < DEPTH);
         if (pend) begin
            ej   = '0;
            ek   = pmask;
            pend = 1'b0;
         end else if (q.size() > 0) begin
            c      = q.pop_front();
            popped = 1'b1;
            ecnt   = ecnt + 16'd1;
            case (c.op)
               2'd0: begin ej = c.m; ek = '0;  rq = rq | c.m;  end
               2'd1: begin ej = '0;  ek = c.m; rq = rq & ~c.m; end
               2'd2: begin ej = c.m; ek = c.m; rq = rq ^ c.m;  end
               default: begin ej = c.m; ek = '0; pend = 1'b1; pmask = c.m; rq = rq & ~c.m; end
            endcase
         end else begin
            ej = '0;
            ek = '0;
         end
         if (last_acc) begin
            n.op = op;
            n.m  = m;
            q.push_back(n);
         end
      end
      reset     = rst;
      cmd_valid = v;
      cmd_op    = op;
      cmd_mask  = m;
      @(posedge clk);
      #1;
      dq = (dq & ~J & ~K) | (J & ~K) | (J & K & ~dq);
      chk("J", J, ej);
      chk("K", K, ek);
      chk("cmd_ready", cmd_ready, (q.size() < DEPTH));
      chk("busy", busy, !rst && (q.size() > 0 || pend || popped));
      if (!pend) chk("downstream", dq, rq);
`ifdef JK_CMD_ISSUER_COUNT_EN
      chk("issue_count", issue_count, ecnt);
`endif
   endtask

   // Hold a command valid until the model says it is accepted (bounded).
   task automatic send(input logic [1:0] op, input logic [31:0] m);
      logic done;
      done = 1'b0;
      for (int t = 0; t < 32 && !done; t++) begin
         if (q.size() >= DEPTH) saw_full = 1'b1;
         cyc(1'b1, op, m, 1'b0);
         done = last_acc;
      end
      if (!done) chk("send_timeout", 64'd0, 64'd1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 2'd0, 32'd0, 1'b0);
   endtask

   initial begin
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 2'd0;
      cmd_mask  = '0;
      saw_full  = 1'b0;

      // reset state, with a command offered during reset
      cyc(1'b1, 2'd0, 32'hFFFF_FFFF, 1'b1);
      cyc(1'b0, 2'd0, 32'd0, 1'b1);
      chk("rst_J", J, 64'd0);
      chk("rst_ready", cmd_ready, 64'd1);
      chk("rst_busy", busy, 64'd0);
      idle(2);

      // single SET: visible one edge after acceptance, for one cycle
      send(2'd0, 32'h0000_00FF);
      chk("set_busy", busy, 64'd1);
      idle(1);
      chk("set_J_e2", J, 64'h0000_00FF);
      chk("set_K_e2", K, 64'd0);
      idle(1);
      chk("set_J_e3", J, 64'd0);
      idle(2);

      // PULSE leaves the downstream bank where it was
      send(2'd1, 32'hFFFF_FFFF);
      idle(3);
      send(2'd3, 32'h8000_0001);
      idle(1);
      chk("pulse_J", J, 64'h8000_0001);
      chk("pulse_K", K, 64'd0);
      idle(1);
      chk("pulse_clr_J", J, 64'd0);
      chk("pulse_clr_K", K, 64'h8000_0001);
      idle(1);
      chk("pulse_restore", dq, 64'd0);
      idle(2);

      // back-to-back SET/CLR/TOG
      send(2'd0, 32'h1);
      send(2'd1, 32'h2);
      chk("b2b_set", J, 64'h1);
      send(2'd2, 32'h4);
      chk("b2b_clr", K, 64'h2);
      idle(1);
      chk("b2b_tog_J", J, 64'h4);
      chk("b2b_tog_K", K, 64'h4);
      idle(3);

      // pulses stall the issuer long enough for the FIFO to fill
      saw_full = 1'b0;
      for (int i = 0; i < 8; i++) send(2'd3, 32'h1 << i);
      send(2'd0, 32'h0001_0000);
      chk("fifo_full_seen", saw_full, 64'd1);
      idle(20);
      chk("drain_busy", busy, 64'd0);

      // reset during PULSE_CLR with two entries queued
      send(2'd3, 32'h0000_0100);
      send(2'd3, 32'h0000_0200);
      send(2'd0, 32'h0000_0400);
      send(2'd0, 32'h0000_0800);
      chk("pre_rst_depth", q.size(), 64'd2);
      chk("pre_rst_pend", pend, 64'd1);
      cyc(1'b0, 2'd0, 32'd0, 1'b1);
      chk("mid_rst_J", J, 64'd0);
      chk("mid_rst_K", K, 64'd0);
      chk("mid_rst_busy", busy, 64'd0);
      chk("mid_rst_ready", cmd_ready, 64'd1);
      idle(6);

      // random traffic with occasional resets
      for (int i = 0; i < 600; i++) begin
         cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
             ($urandom_range(0, 59) == 0));
      end
      idle(20);

`ifdef JK_CMD_ISSUER_COUNT_EN
      // issue counter wraps after 0x10000 pops
      cyc(1'b0, 2'd0, 32'd0, 1'b1);
      chk("cnt_rst", issue_count, 64'd0);
      for (int i = 0; i < 32'h10001; i++) send(2'd0, 32'h1);
      idle(4);
      chk("count_wrap", issue_count, 64'd1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
